// File: rtl/axis_iq_deinterleaver.sv
// Pairs two 4-sample interleaved IQ beats into lock-stepped 8-sample real/imag output words.
// Build option: define AXIS_IQ_SWAP_EN to take Q from the low half and I from the high half of each sample.
module axis_iq_deinterleaver #(
  parameter int unsigned SDATA_WIDTH  = 128,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned MDATA_WIDTH  = 128,
  parameter int unsigned FCNT_WIDTH   = 16
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [SDATA_WIDTH-1:0]     s_axis_mm2s_tdata,
  input  logic [SDATA_WIDTH/8-1:0]   s_axis_mm2s_tkeep,
  input  logic                       s_axis_mm2s_tvalid,
  output logic                       s_axis_mm2s_tready,
  input  logic                       s_axis_mm2s_tlast,
  output logic [MDATA_WIDTH-1:0]     m_axis_real_tdata,
  output logic [MDATA_WIDTH/8-1:0]   m_axis_real_tkeep,
  output logic                       m_axis_real_tvalid,
  input  logic                       m_axis_real_tready,
  output logic                       m_axis_real_tlast,
  output logic [MDATA_WIDTH-1:0]     m_axis_imag_tdata,
  output logic [MDATA_WIDTH/8-1:0]   m_axis_imag_tkeep,
  output logic                       m_axis_imag_tvalid,
  input  logic                       m_axis_imag_tready,
  output logic                       m_axis_imag_tlast,
  output logic [FCNT_WIDTH-1:0]      frame_count
);
  localparam int unsigned NS  = SDATA_WIDTH / (2 * SAMPLE_WIDTH);
  localparam int unsigned IKB = (2 * SAMPLE_WIDTH) / 8;
  localparam int unsigned OKB = SAMPLE_WIDTH / 8;
  localparam int unsigned MKW = MDATA_WIDTH / 8;

  typedef enum logic {S_EMPTY, S_HALF} state_t;

  state_t                      r_state, w_state_nxt;
  logic [NS*SAMPLE_WIDTH-1:0]  w_beat_i, w_beat_q, r_half_i, r_half_q;
  logic [NS*OKB-1:0]           w_beat_okeep, r_half_okeep;
  logic [MDATA_WIDTH-1:0]      r_out_i, r_out_q;
  logic [MKW-1:0]              r_out_keep;
  logic                        r_out_valid, r_out_last;
  logic [FCNT_WIDTH-1:0]       r_frame_count;
  logic                        w_out_fire, w_in_fire, w_kept;
  logic                        w_half_load, w_single_load, w_pair_load;

  assign w_out_fire         = r_out_valid & m_axis_real_tready & m_axis_imag_tready;
  assign s_axis_mm2s_tready = resetn & (~r_out_valid | w_out_fire);
  assign w_in_fire          = s_axis_mm2s_tvalid & s_axis_mm2s_tready;

  // Partially-qualified samples are zeroed and their output byte qualifiers cleared.
  always_comb begin
    w_beat_i     = '0;
    w_beat_q     = '0;
    w_beat_okeep = '0;
    w_kept       = 1'b0;
    for (int unsigned k = 0; k < NS; k++) begin
      w_kept = &s_axis_mm2s_tkeep[k*IKB +: IKB];
      w_beat_okeep[k*OKB +: OKB] = {OKB{w_kept}};
      if (w_kept) begin
`ifdef AXIS_IQ_SWAP_EN
        w_beat_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_axis_mm2s_tdata[2*k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        w_beat_i[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_axis_mm2s_tdata[(2*k+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
`else
        w_beat_i[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_axis_mm2s_tdata[2*k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        w_beat_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_axis_mm2s_tdata[(2*k+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
`endif
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_half_load   = 1'b0;
    w_single_load = 1'b0;
    w_pair_load   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          if (s_axis_mm2s_tlast) begin
            w_single_load = 1'b1;
          end else begin
            w_half_load = 1'b1;
            w_state_nxt = S_HALF;
          end
        end
      end
      S_HALF: begin
        if (w_in_fire) begin
          w_pair_load = 1'b1;
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_EMPTY;
      r_half_i     <= '0;
      r_half_q     <= '0;
      r_half_okeep <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_half_load) begin
        r_half_i     <= w_beat_i;
        r_half_q     <= w_beat_q;
        r_half_okeep <= w_beat_okeep;
      end
    end
  end

  // A load in the same cycle as a retire replaces the word without dropping valid.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_i       <= '0;
      r_out_q       <= '0;
      r_out_keep    <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_single_load) begin
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b1;
        r_out_i     <= MDATA_WIDTH'(w_beat_i);
        r_out_q     <= MDATA_WIDTH'(w_beat_q);
        r_out_keep  <= MKW'(w_beat_okeep);
      end else if (w_pair_load) begin
        r_out_valid <= 1'b1;
        r_out_last  <= s_axis_mm2s_tlast;
        r_out_i     <= {w_beat_i, r_half_i};
        r_out_q     <= {w_beat_q, r_half_q};
        r_out_keep  <= {w_beat_okeep, r_half_okeep};
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_out_fire && r_out_last) begin
        r_frame_count <= r_frame_count + FCNT_WIDTH'(1);
      end
    end
  end

  assign m_axis_real_tdata  = r_out_i;
  assign m_axis_imag_tdata  = r_out_q;
  assign m_axis_real_tkeep  = r_out_keep;
  assign m_axis_imag_tkeep  = r_out_keep;
  assign m_axis_real_tvalid = r_out_valid;
  assign m_axis_imag_tvalid = r_out_valid;
  assign m_axis_real_tlast  = r_out_last;
  assign m_axis_imag_tlast  = r_out_last;
  assign frame_count        = r_frame_count;

endmodule

// File: tb/tb_axis_iq_deinterleaver.sv
// Self-checking bench for axis_iq_deinterleaver: directed cases plus random traffic against a frame-level model.
module tb_axis_iq_deinterleaver;
  logic         clock = 1'b0;
  logic         resetn;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tvalid, s_tready, s_tlast;
  logic [127:0] r_tdata, i_tdata;
  logic [15:0]  r_tkeep, i_tkeep;
  logic         r_tvalid, r_tready, r_tlast;
  logic         i_tvalid, i_tready, i_tlast;
  logic [15:0]  frame_count;

  always #5 clock = ~clock;

  axis_iq_deinterleaver #(.SDATA_WIDTH(128), .SAMPLE_WIDTH(16), .MDATA_WIDTH(128), .FCNT_WIDTH(16)) dut (
    .clock(clock), .resetn(resetn),
    .s_axis_mm2s_tdata(s_tdata), .s_axis_mm2s_tkeep(s_tkeep), .s_axis_mm2s_tvalid(s_tvalid),
    .s_axis_mm2s_tready(s_tready), .s_axis_mm2s_tlast(s_tlast),
    .m_axis_real_tdata(r_tdata), .m_axis_real_tkeep(r_tkeep), .m_axis_real_tvalid(r_tvalid),
    .m_axis_real_tready(r_tready), .m_axis_real_tlast(r_tlast),
    .m_axis_imag_tdata(i_tdata), .m_axis_imag_tkeep(i_tkeep), .m_axis_imag_tvalid(i_tvalid),
    .m_axis_imag_tready(i_tready), .m_axis_imag_tlast(i_tlast),
    .frame_count(frame_count)
  );

  typedef struct { logic [127:0] d; logic [15:0] k; } beat_t;
  typedef struct { logic [127:0] re; logic [127:0] im; logic [15:0] kp; logic l; } word_t;

  beat_t        cur_beats[$];
  word_t        exp_q[$];
  logic [15:0]  exp_fc;
  int           checks = 0, errors = 0;
  int           words_seen = 0, stall_cycles = 0;
  int           rmode = 0, stall_cnt = 0;
  logic [127:0] last_re, last_im;
  logic [15:0]  last_kp;
  logic         prev_hold = 1'b0;
  word_t        held;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame-level model: samples are gathered across the beats of the current word, then padded to 8.
  function automatic word_t build_word(input logic last);
    word_t        w;
    logic [31:0]  cs;
    int           nsamp;
    w.re = '0; w.im = '0; w.kp = '0; w.l = last;
    nsamp = 4 * cur_beats.size();
    for (int s = 0; s < nsamp; s++) begin
      cs = cur_beats[s / 4].d[32*(s % 4) +: 32];
      if (cur_beats[s / 4].k[4*(s % 4) +: 4] == 4'hF) begin
`ifdef AXIS_IQ_SWAP_EN
        w.re[16*s +: 16] = cs[31:16];
        w.im[16*s +: 16] = cs[15:0];
`else
        w.re[16*s +: 16] = cs[15:0];
        w.im[16*s +: 16] = cs[31:16];
`endif
        w.kp[2*s +: 2] = 2'b11;
      end
    end
    return w;
  endfunction

  function automatic void model_accept(input logic [127:0] d, input logic [15:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k;
    cur_beats.push_back(b);
    if (l || cur_beats.size() == 2) begin
      exp_q.push_back(build_word(l));
      cur_beats.delete();
    end
  endfunction

  function automatic logic [127:0] mk(input logic [15:0] ib, input logic [15:0] qb);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) begin
      r[32*k +: 16]    = ib + 16'(k);
      r[32*k+16 +: 16] = qb + 16'(k);
    end
    return r;
  endfunction

  always @(negedge clock) begin
    case (rmode)
      0: begin r_tready = 1'b1; i_tready = 1'b1; end
      1: begin r_tready = ($urandom % 4) != 0; i_tready = ($urandom % 4) != 0; end
      default: begin
        r_tready = 1'b1;
        i_tready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
      end
    endcase
  end

  // Output monitor samples 2 time units before each rising edge.
  always @(negedge clock) begin
    word_t w;
    logic  fire;
    #3;
    if (!resetn) begin
      chk("reset_outputs", {r_tdata, i_tdata, r_tkeep, i_tkeep, r_tvalid, i_tvalid, r_tlast, i_tlast, s_tready, frame_count}, '0);
      prev_hold = 1'b0;
    end else begin
      chk("lockstep", {r_tvalid, r_tlast, r_tdata, r_tkeep}, {i_tvalid, i_tlast, r_tdata, i_tkeep});
      chk("out_valid", r_tvalid, exp_q.size() != 0);
      chk("frame_count", frame_count, exp_fc);
      if (prev_hold)
        chk("hold_stable", {r_tdata, i_tdata, r_tkeep, r_tlast}, {held.re, held.im, held.kp, held.l});
      fire = r_tvalid & r_tready & i_tready;
      if (fire && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("word_real", r_tdata, w.re);
        chk("word_imag", i_tdata, w.im);
        chk("word_keep_last", {r_tkeep, r_tlast}, {w.kp, w.l});
        last_re = r_tdata; last_im = i_tdata; last_kp = r_tkeep;
        words_seen++;
        if (w.l) exp_fc = exp_fc + 16'd1;
      end
      prev_hold = r_tvalid & ~fire;
      held.re = r_tdata; held.im = i_tdata; held.kp = r_tkeep; held.l = r_tlast;
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    bit accepted = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    for (int c = 0; c < 100 && !accepted; c++) begin
      #4;
      chk("s_tready", s_tready, exp_q.size() == 0);
      if (s_tready) begin
        accepted = 1;
        model_accept(d, k, l);
      end else begin
        stall_cycles++;
      end
      @(negedge clock);
    end
    if (!accepted) chk("accept_timeout", 1'b0, 1'b1);
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0; s_tvalid = 1'b0;
    cur_beats.delete(); exp_q.delete(); exp_fc = '0; prev_hold = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(1);
  endtask

  initial begin
    logic [127:0] e_re1, e_im1, e_re2, e_im2;
    int           w0, s0;
    logic [15:0]  fc0;
    logic         l;
    logic [15:0]  k;
`ifdef AXIS_IQ_SWAP_EN
    e_re1 = 128'h0018_0017_0016_0015_0014_0013_0012_0011; e_im1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    e_re2 = '0; e_im2 = 128'h0000_0000_0000_0000_0004_0003_0002_0001;
`else
    e_re1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001; e_im1 = 128'h0018_0017_0016_0015_0014_0013_0012_0011;
    e_re2 = 128'h0000_0000_0000_0000_0004_0003_0002_0001; e_im2 = '0;
`endif
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    r_tready = 1'b1; i_tready = 1'b1;
    @(negedge clock);
    do_reset();

    // Two-beat frame
    send_beat(mk(16'h1, 16'h11), 16'hFFFF, 1'b0);
    send_beat(mk(16'h5, 16'h15), 16'hFFFF, 1'b1);
    idle(3);
    chk("t1_real", last_re, e_re1);
    chk("t1_imag", last_im, e_im1);
    chk("t1_keep", last_kp, 16'hFFFF);
    chk("t1_fc", frame_count, 16'd1);

    // Single-beat frame
    send_beat(128'h0000_0004_0000_0003_0000_0002_0000_0001, 16'hFFFF, 1'b1);
    idle(3);
    chk("t2_real", last_re, e_re2);
    chk("t2_imag", last_im, e_im2);
    chk("t2_keep", last_kp, 16'h00FF);

    // 64 continuous beats in one frame
    w0 = words_seen; s0 = stall_cycles; fc0 = frame_count;
    for (int b = 0; b < 64; b++) send_beat(mk(16'(b * 8), 16'(b * 8 + 16'h400)), 16'hFFFF, b == 63);
    idle(3);
    chk("t3_words", words_seen - w0, 32);
    chk("t3_stalls", stall_cycles - s0, 0);
    chk("t3_fc", frame_count - fc0, 16'd1);

    // Imag tready low for 10 cycles mid-stream
    s0 = stall_cycles; w0 = words_seen;
    send_beat(mk(16'h100, 16'h200), 16'hFFFF, 1'b0);
    send_beat(mk(16'h104, 16'h204), 16'hFFFF, 1'b0);
    rmode = 2; stall_cnt = 10;
    for (int b = 0; b < 8; b++) send_beat(mk(16'(16'h110 + b * 4), 16'(16'h210 + b * 4)), 16'hFFFF, b == 7);
    rmode = 0;
    idle(3);
    chk("t4_stalled", stall_cycles - s0 > 0, 1'b1);
    chk("t4_words", words_seen - w0, 5);

    // Partial keep on the last beat
    send_beat(mk(16'h21, 16'h31), 16'hFFFF, 1'b0);
    send_beat(mk(16'h25, 16'h35), 16'h00FF, 1'b1);
    idle(3);
    chk("t5_keep", last_kp, 16'h0FFF);
    chk("t5_hi_zero", {last_re[127:96], last_im[127:96]}, '0);

    // Reset while holding half a word
    send_beat(mk(16'h41, 16'h51), 16'hFFFF, 1'b0);
    idle(2);
    do_reset();
    idle(3);
    chk("t6_fc_zero", frame_count, 16'd0);
    chk("t6_no_output", r_tvalid, 1'b0);
    send_beat(mk(16'h61, 16'h71), 16'hFFFF, 1'b0);
    send_beat(mk(16'h65, 16'h75), 16'hFFFF, 1'b1);
    idle(3);
    chk("t6_fc_one", frame_count, 16'd1);

    // Random traffic with random readies, frame ends and keeps
    rmode = 1;
    for (int b = 0; b < 300; b++) begin
      l = ($urandom % 5) == 0;
      k = (($urandom % 6) == 0) ? 16'($urandom) : 16'hFFFF;
      send_beat({$urandom, $urandom, $urandom, $urandom}, k, l);
      if (($urandom % 8) == 0) idle($urandom_range(1, 3));
    end
    send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b1);
    rmode = 0;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clock);
    idle(2);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
